// File: rtl/sdc_cmd_sched.sv
// SDRAM command scheduler: two-port round-robin arbiter driving ACT/RD/WR/PRE sequences.
// Define AUTO_REFRESH_EN to include the periodic refresh counter and the REF/TRFC states.
module sdc_cmd_sched #(
    parameter int TRCD  = 2,
    parameter int TRP   = 2,
    parameter int TRFC  = 7,
    parameter int TREFI = 780
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [23:0] adr0,
    input  logic [23:0] adr1,
    input  logic [1:0]  len0,
    input  logic [1:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [1:0]  cfg_bl,
    output logic [2:0]  sdc_cmd,
    output logic [1:0]  sdc_ba,
    output logic [11:0] sdc_addr,
    output logic        sdc_read,
    output logic        sdc_write,
    output logic [1:0]  req_len,
    output logic        busy
);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;

    // One shared down-counter width covers the largest timing parameter.
    localparam int M1    = (TRCD > TRP) ? TRCD : TRP;
    localparam int M2    = (TRFC > TREFI) ? TRFC : TREFI;
    localparam int MAX_T = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] TRCD_LD  = CW'((TRCD > 1) ? (TRCD - 2) : 0);
    localparam logic [CW-1:0] TRP_LD   = CW'((TRP > 1) ? (TRP - 2) : 0);
    localparam bit            TRCD_WAIT = (TRCD > 1);
    localparam bit            TRP_WAIT  = (TRP > 1);
`ifdef AUTO_REFRESH_EN
    localparam logic [2:0]    CMD_REF   = 3'b001;
    localparam logic [CW-1:0] TRFC_LD   = CW'((TRFC > 1) ? (TRFC - 2) : 0);
    localparam logic [CW-1:0] REFI_LD   = CW'(TREFI - 1);
    localparam bit            TRFC_WAIT = (TRFC > 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_TRCD, S_XFER, S_PRE, S_TRP, S_REF, S_TRFC
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           last_q;
    logic           we_q;
    logic [1:0]     bl_q;
    logic [9:0]     col_q;
    logic [1:0]     beat_q;
    logic [1:0]     bursts_q;
    logic           gnt0_q;
    logic           gnt1_q;
    logic [2:0]     cmd_q;
    logic [1:0]     ba_q;
    logic [11:0]    addr_q;
    logic           rd_q;
    logic           wr_q;
    logic [1:0]     len_q;
    logic           busy_q;
    logic           ref_pending_q;

    logic           win1_s;
    logic           sel_we_s;
    logic [23:0]    sel_adr_s;
    logic [1:0]     sel_len_s;
    logic           go_xfer_s;

    // Words per burst for the latched burst-length code.
    function automatic logic [9:0] bl_words(input logic [1:0] bl);
        case (bl)
            2'b00:   bl_words = 10'd1;
            2'b01:   bl_words = 10'd2;
            2'b10:   bl_words = 10'd4;
            default: bl_words = 10'd8;
        endcase
    endfunction

    // Extra cycles a burst occupies after its RD/WR cycle: max(1, BL/2) - 1.
    function automatic logic [1:0] beat_ld(input logic [1:0] bl);
        case (bl)
            2'b00:   beat_ld = 2'd0;
            2'b01:   beat_ld = 2'd0;
            2'b10:   beat_ld = 2'd1;
            default: beat_ld = 2'd3;
        endcase
    endfunction

    // Round-robin winner and the request fields it selects.
    always_comb begin
        win1_s    = 1'b0;
        sel_we_s  = we0;
        sel_adr_s = adr0;
        sel_len_s = len0;
        if (req1 && (!req0 || !last_q)) begin
            win1_s    = 1'b1;
            sel_we_s  = we1;
            sel_adr_s = adr1;
            sel_len_s = len1;
        end else begin
            win1_s    = 1'b0;
        end
    end

    // ACT/TRCD hand over to XFER once the activate-to-column delay has elapsed.
    always_comb begin
        go_xfer_s = 1'b0;
        if (state_q == S_ACT) begin
            go_xfer_s = !TRCD_WAIT;
        end else if (state_q == S_TRCD) begin
            go_xfer_s = (cnt_q == '0);
        end else begin
            go_xfer_s = 1'b0;
        end
    end

`ifdef AUTO_REFRESH_EN
    logic [CW-1:0] ref_cnt_q;
    logic          ref_clr_s;

    assign ref_clr_s = (state_q == S_IDLE) && ref_pending_q;

    // Refresh interval counter; an expiry wins over a same-cycle clear so no refresh is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q     <= REFI_LD;
            ref_pending_q <= 1'b0;
        end else begin
            if (ref_cnt_q == '0) begin
                ref_cnt_q     <= REFI_LD;
                ref_pending_q <= 1'b1;
            end else begin
                ref_cnt_q     <= ref_cnt_q - CNT_ONE;
                ref_pending_q <= ref_clr_s ? 1'b0 : ref_pending_q;
            end
        end
    end
`else
    assign ref_pending_q = 1'b0;
`endif

    // Command FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            bl_q     <= 2'b00;
            col_q    <= 10'd0;
            beat_q   <= 2'd0;
            bursts_q <= 2'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            cmd_q    <= CMD_NOP;
            ba_q     <= 2'b00;
            addr_q   <= 12'h000;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            len_q    <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef AUTO_REFRESH_EN
                    if (ref_pending_q) begin
                        state_q <= S_REF;
                        cmd_q   <= CMD_REF;
                        busy_q  <= 1'b1;
                    end else
`endif
                    if (req0 || req1) begin
                        state_q <= S_ACT;
                        gnt0_q  <= !win1_s;
                        gnt1_q  <= win1_s;
                        last_q  <= win1_s;
                        we_q    <= sel_we_s;
                        col_q   <= sel_adr_s[9:0];
                        len_q   <= sel_len_s;
                        bl_q    <= cfg_bl;
                        cmd_q   <= CMD_ACT;
                        ba_q    <= sel_adr_s[23:22];
                        addr_q  <= sel_adr_s[21:10];
                        busy_q  <= 1'b1;
                    end else begin
                        cmd_q  <= CMD_NOP;
                        busy_q <= 1'b0;
                    end
                end
                S_ACT, S_TRCD: begin
                    if (go_xfer_s) begin
                        state_q  <= S_XFER;
                        cmd_q    <= we_q ? CMD_WR : CMD_RD;
                        addr_q   <= {2'b00, col_q};
                        col_q    <= col_q + bl_words(bl_q);
                        beat_q   <= beat_ld(bl_q);
                        bursts_q <= len_q;
                        rd_q     <= !we_q;
                        wr_q     <= we_q;
                    end else begin
                        state_q <= S_TRCD;
                        cmd_q   <= CMD_NOP;
                        cnt_q   <= (state_q == S_ACT) ? TRCD_LD : (cnt_q - CNT_ONE);
                    end
                end
                S_XFER: begin
                    if (beat_q != 2'd0) begin
                        beat_q <= beat_q - 2'd1;
                        cmd_q  <= CMD_NOP;
                    end else if (bursts_q != 2'd0) begin
                        bursts_q <= bursts_q - 2'd1;
                        cmd_q    <= we_q ? CMD_WR : CMD_RD;
                        addr_q   <= {2'b00, col_q};
                        col_q    <= col_q + bl_words(bl_q);
                        beat_q   <= beat_ld(bl_q);
                    end else begin
                        state_q <= S_PRE;
                        cmd_q   <= CMD_PRE;
                        addr_q  <= 12'h400;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                S_PRE: begin
                    cmd_q <= CMD_NOP;
                    if (TRP_WAIT) begin
                        state_q <= S_TRP;
                        cnt_q   <= TRP_LD;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_TRP: begin
                    cmd_q <= CMD_NOP;
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
`ifdef AUTO_REFRESH_EN
                S_REF: begin
                    cmd_q <= CMD_NOP;
                    if (TRFC_WAIT) begin
                        state_q <= S_TRFC;
                        cnt_q   <= TRFC_LD;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_TRFC: begin
                    cmd_q <= CMD_NOP;
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    cmd_q   <= CMD_NOP;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sdc_cmd   = cmd_q;
    assign sdc_ba    = ba_q;
    assign sdc_addr  = addr_q;
    assign sdc_read  = rd_q;
    assign sdc_write = wr_q;
    assign req_len   = len_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdc_cmd_sched.sv
// Scoreboard bench for sdc_cmd_sched: expected per-cycle activity is queued with each
// request; a forked monitor pops and compares on every non-idle output cycle.
module tb_sdc_cmd_sched;

    localparam int TRCD_P  = 2;
    localparam int TRP_P   = 2;
    localparam int TRFC_P  = 7;
    localparam int TREFI_P = 500;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [23:0] adr0 = 24'h0, adr1 = 24'h0;
    logic [1:0]  len0 = 2'b00, len1 = 2'b00, cfg_bl = 2'b00;
    logic        gnt0, gnt1, sdc_read, sdc_write, busy;
    logic [2:0]  sdc_cmd;
    logic [1:0]  sdc_ba, req_len;
    logic [11:0] sdc_addr;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
        logic        rd;
        logic        wr;
        logic        busy;
        logic [1:0]  rlen;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b1;

    sdc_cmd_sched #(.TRCD(TRCD_P), .TRP(TRP_P), .TRFC(TRFC_P), .TREFI(TREFI_P)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .cfg_bl(cfg_bl),
        .sdc_cmd(sdc_cmd), .sdc_ba(sdc_ba), .sdc_addr(sdc_addr),
        .sdc_read(sdc_read), .sdc_write(sdc_write),
        .req_len(req_len), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ev(input int idx, input ev_t a, input ev_t e);
        bit ok;
        ok = (a.gnt === e.gnt) && (a.cmd === e.cmd) && (a.rd === e.rd) &&
             (a.wr === e.wr) && (a.busy === e.busy);
        if (e.cmd == ACT) ok = ok && (a.ba === e.ba) && (a.addr === e.addr) && (a.rlen === e.rlen);
        if (e.cmd == RD || e.cmd == WR) ok = ok && (a.ba === e.ba) && (a.addr[10:0] === e.addr[10:0]);
        if (e.cmd == PRE) ok = ok && (a.addr[10] === 1'b1);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL event%0d actual gnt=%b cmd=%b ba=%0d addr=%h rd=%b wr=%b busy=%b len=%0d expected gnt=%b cmd=%b ba=%0d addr=%h rd=%b wr=%b busy=%b len=%0d",
                     idx, a.gnt, a.cmd, a.ba, a.addr, a.rd, a.wr, a.busy, a.rlen,
                     e.gnt, e.cmd, e.ba, e.addr, e.rd, e.wr, e.busy, e.rlen);
        end
    endtask

    task automatic monitor();
        ev_t a;
        ev_t e;
        int  idx = 0;
        forever begin
            @(negedge clk);
            if (mon_en && (gnt0 || gnt1 || sdc_cmd != NOP || sdc_read || sdc_write || busy)) begin
                a = {gnt1, gnt0, sdc_cmd, sdc_ba, sdc_addr, sdc_read, sdc_write, busy, req_len};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual cmd=%b gnt=%b busy=%b expected no activity",
                             sdc_cmd, {gnt1, gnt0}, busy);
                end else begin
                    e = exp_q.pop_front();
                    chk_ev(idx, a, e);
                end
                idx++;
            end
        end
    endtask

    function automatic ev_t mk(input logic [1:0] g, input logic [2:0] c, input logic [1:0] ba,
                               input logic [11:0] ad, input logic r, input logic w, input logic [1:0] l);
        ev_t e;
        e = {g, c, ba, ad, r, w, 1'b1, l};
        return e;
    endfunction

    task automatic push_nops(input int n, input logic r, input logic w);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(2'b00, NOP, 2'b00, 12'h000, r, w, 2'b00));
    endtask

    // Expected cycle stream of one granted transfer, ACT through the end of TRP.
    task automatic push_xfer(input int port, input logic we, input logic [23:0] adr,
                             input logic [1:0] len, input logic [1:0] bl);
        int         words;
        int         bc;
        logic [9:0] col;
        words = 1 << bl;
        bc    = (words / 2 > 1) ? words / 2 : 1;
        exp_q.push_back(mk((port == 0) ? 2'b01 : 2'b10, ACT, adr[23:22], adr[21:10], 1'b0, 1'b0, len));
        push_nops(TRCD_P - 1, 1'b0, 1'b0);
        for (int k = 0; k <= int'(len); k++) begin
            col = 10'((int'(adr[9:0]) + k * words) % 1024);
            exp_q.push_back(mk(2'b00, we ? WR : RD, adr[23:22], {2'b00, col}, !we, we, 2'b00));
            push_nops(bc - 1, !we, we);
        end
        exp_q.push_back(mk(2'b00, PRE, 2'b00, 12'h400, 1'b0, 1'b0, 2'b00));
        push_nops(TRP_P - 1, 1'b0, 1'b0);
    endtask

    task automatic drive(input int port, input logic we, input logic [23:0] adr, input logic [1:0] len);
        bit got = 1'b0;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; adr0 = adr; len0 = len;
        end else begin
            req1 = 1'b1; we1 = we; adr1 = adr; len1 = len;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? gnt0 : gnt1;
        end
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
        chk((port == 0) ? "grant_port0" : "grant_port1", 32'(got), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        bit          seen;
        int          bad;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(sdc_cmd), 32'(NOP));
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_rdwr", 32'({sdc_read, sdc_write}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ba", 32'(sdc_ba), 32'd0);
        chk("rst_addr", 32'(sdc_addr), 32'd0);
        chk("rst_len", 32'(req_len), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read, BL=4: ACT bank 1 row 0, RD col 0x123, two read cycles.
        cfg_bl = 2'b10;
        push_xfer(0, 1'b0, 24'h400123, 2'd0, 2'b10);
        drive(0, 1'b0, 24'h400123, 2'd0);
        wait_drain("rd_bl4");

        // Write BL=8, two bursts wrapping 0x3FC -> 0x004; cfg_bl change after grant is ignored.
        cfg_bl = 2'b11;
        a = {2'b10, 12'h055, 10'h3FC};
        push_xfer(1, 1'b1, a, 2'd1, 2'b11);
        drive(1, 1'b1, a, 2'd1);
        cfg_bl = 2'b00;
        wait_drain("wr_bl8_wrap");

        // BL=1, four single-cycle bursts crossing the column wrap.
        a = {2'b11, 12'hABC, 10'h3FE};
        push_xfer(0, 1'b0, a, 2'd3, 2'b00);
        drive(0, 1'b0, a, 2'd3);
        wait_drain("rd_bl1");

        // BL=2, three write bursts stepping by two.
        cfg_bl = 2'b01;
        a = {2'b00, 12'hFFF, 10'h010};
        push_xfer(1, 1'b1, a, 2'd2, 2'b01);
        drive(1, 1'b1, a, 2'd2);
        wait_drain("wr_bl2");

        // Simultaneous requests after reset: port0, then port1, then port0 again.
        do_reset();
        push_xfer(0, 1'b0, 24'h123456, 2'd0, 2'b01);
        push_xfer(1, 1'b1, 24'h654321, 2'd1, 2'b01);
        push_xfer(0, 1'b1, 24'hC00ABC, 2'd0, 2'b01);
        fork
            begin
                drive(0, 1'b0, 24'h123456, 2'd0);
                drive(0, 1'b1, 24'hC00ABC, 2'd0);
            end
            drive(1, 1'b1, 24'h654321, 2'd1);
        join
        wait_drain("round_robin");

        // A req1 withdrawn before grant leaves no trace.
        cfg_bl = 2'b11;
        push_xfer(0, 1'b0, 24'h2A5001, 2'd1, 2'b11);
        fork
            drive(0, 1'b0, 24'h2A5001, 2'd1);
            begin
                repeat (3) @(negedge clk);
                req1 = 1'b1; we1 = 1'b1; adr1 = 24'h111111; len1 = 2'd0;
                repeat (3) @(negedge clk);
                req1 = 1'b0;
            end
        join
        wait_drain("dropped_req");

        // Reset during XFER returns to idle at once.
        do_reset();
        mon_en = 1'b0;
        cfg_bl = 2'b10;
        drive(0, 1'b0, 24'h000200, 2'd3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (sdc_read) seen = 1'b1;
            else @(negedge clk);
        end
        chk("xfer_reached", 32'(seen), 32'd1);
        rst = 1'b1;
        #2;
        chk("midrst_cmd", 32'(sdc_cmd), 32'(NOP));
        chk("midrst_read", 32'(sdc_read), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_cmd", 32'(sdc_cmd), 32'(NOP));
        chk("postrst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

`ifdef AUTO_REFRESH_EN
        // Expiry lands mid-transfer: transfer, PRE, TRP, then REF ahead of waiting req1.
        do_reset();
        repeat (490) @(posedge clk);
        @(negedge clk);
        cfg_bl = 2'b11;
        push_xfer(0, 1'b0, 24'h4ABC00, 2'd3, 2'b11);
        exp_q.push_back(mk(2'b00, REF, 2'b00, 12'h000, 1'b0, 1'b0, 2'b00));
        push_nops(TRFC_P - 1, 1'b0, 1'b0);
        push_xfer(1, 1'b1, 24'h800040, 2'd0, 2'b10);
        fork
            drive(0, 1'b0, 24'h4ABC00, 2'd3);
            begin
                repeat (6) @(negedge clk);
                cfg_bl = 2'b10;
                drive(1, 1'b1, 24'h800040, 2'd0);
            end
        join
        wait_drain("refresh");
`else
        // Without auto-refresh, a long idle stretch never issues a command.
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (sdc_cmd != NOP) bad++;
        end
        chk("idle_no_cmd", 32'(bad), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdc_cmd_sched.md
SDC_CMD_SCHED -- requirements
Module: sdc_cmd_sched

Interface
REQ-001 Parameter TRCD, default 2, ACTIVE-to-READ/WRITE delay in clk cycles (minimum 1).
REQ-002 Parameter TRP, default 2, PRECHARGE-to-next-command delay in clk cycles (minimum 1).
REQ-003 Parameter TRFC, default 7, REFRESH-to-next-command delay in clk cycles (minimum 1).
REQ-004 Parameter TREFI, default 780, refresh interval in clk cycles.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req0 / req1  in  1  transfer request, port 0 / port 1; held until granted.
REQ-008 we0 / we1  in  1  1 = write, 0 = read; per port; valid with req.
REQ-009 adr0 / adr1  in  24  address per port: bank[23:22], row[21:10], col[9:0].
REQ-010 len0 / len1  in  2  number of bursts minus 1, per port.
REQ-011 gnt0 / gnt1  out  1  one-cycle grant pulse, per port.
REQ-012 cfg_bl  in  2  burst length: 00=1, 01=2, 10=4, 11=8.
REQ-013 sdc_cmd  out  3  {RAS_n, CAS_n, WE_n}: NOP=111, ACT=011, RD=101, WR=100, PRE=010, REF=001.
REQ-014 sdc_ba  out  2  bank address.
REQ-015 sdc_addr  out  12  row, or column / precharge-all address.
REQ-016 sdc_read / sdc_write  out  1  datapath read/write enable, active during XFER.
REQ-017 req_len  out  2  latched len of the granted request, to the datapath.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ACT, TRCD, XFER, PRE, TRP, REF, TRFC; all outputs registered.
REQ-020 IDLE with ref_pending set -> REF; else any req -> ACT; else stay IDLE.
REQ-021 Arbitration: round-robin; simultaneous req0 and req1 grant the port not granted last; after reset the last grant is port 1, so port 0 wins first.
REQ-022 On IDLE->ACT: gnt pulse for the winner in that same edge's registered outputs; latch we, adr, len, cfg_bl.
REQ-023 ACT: sdc_cmd=ACT, sdc_ba=bank, sdc_addr=row for 1 cycle; then TRCD.
REQ-024 TRCD: NOP for TRCD-1 cycles; then XFER.
REQ-025 XFER: issue RD/WR on the first cycle of each burst; each burst occupies max(1, BL/2) cycles; NOP on the remaining cycles; len+1 bursts total.
REQ-026 Column of burst k = (col + k*BL) mod 1024; wrap stays within the row; sdc_addr[10]=0 on RD/WR.
REQ-027 sdc_read (read) or sdc_write (write) is high for every XFER cycle and low otherwise.
REQ-028 After the last burst -> PRE: sdc_cmd=PRE, sdc_addr[10]=1 (all banks), 1 cycle; then TRP: NOP for TRP-1 cycles; then IDLE.
REQ-029 Refresh counter counts down from TREFI-1 each cycle; at 0 it sets ref_pending and reloads.
REQ-030 ref_pending never aborts a transfer; it is serviced at the next IDLE, ahead of requests.
REQ-031 REF: sdc_cmd=REF, 1 cycle, clears ref_pending; TRFC: NOP for TRFC-1 cycles; then IDLE.
REQ-032 Expiry coinciding with a REF cycle leaves ref_pending set; at most one pending refresh is held.
REQ-033 cfg_bl changes take effect only at the next grant.
REQ-034 A req deasserted before grant is dropped without effect.

Reset
REQ-035 rst asserted: FSM to IDLE immediately, including mid-transfer.
REQ-036 rst values: sdc_cmd=NOP, gnt0=gnt1=0, sdc_read=sdc_write=0, busy=0, sdc_ba=0, sdc_addr=0, req_len=0, ref_pending=0, refresh counter=TREFI-1.

Configuration
REQ-037 AUTO_REFRESH_EN defined: refresh counter, REF and TRFC states present per REQ-029..REQ-032.
REQ-038 AUTO_REFRESH_EN undefined: counter and refresh states removed; sdc_cmd never issues REF.

Verification
REQ-039 req0=1, we0=0, adr0=0x40_0123, len0=0, BL=4, TRCD=2: ACT bank 1, row 0x000; then NOP; RD col 0x123; sdc_read high 2 cycles; PRE; IDLE.
REQ-040 req0 and req1 asserted together twice in a row: gnt0 is granted first, then gnt1.
REQ-041 Write, col=0x3FC, len=1, BL=8: WR col 0x3FC, then WR col 0x004 (wrap); sdc_write high 8 cycles.
REQ-042 Refresh counter expires during XFER: transfer completes, PRE, TRP, then REF before a waiting req1 is granted.
REQ-043 rst pulsed during XFER: next cycle sdc_cmd=NOP, sdc_read=0, busy=0.
REQ-044 AUTO_REFRESH_EN undefined, idle for 2000 cycles: sdc_cmd stays 111.
